// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared types and constants for the ALU-sequenced multiplier.
//   state_e      : multiplier sequencer states
//   ALU_OP_*     : ALU operation select codes driven on o_ctrlAluOp
//   LAST_BIT     : bit-counter value of the final (MSB) multiplier bit
// -----------------------------------------------------------------------------
package alu_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ISSUE   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_DONE    = 3'd4
    } state_e;

    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_AND   = 2'b01;
    localparam logic [1:0] ALU_OP_XOR   = 2'b10;
    localparam logic [1:0] ALU_OP_SHIFT = 2'b11;

    localparam logic [2:0] LAST_BIT = 3'd7;

endpackage

// File: rtl/alu_mul_seq.sv
// -----------------------------------------------------------------------------
// alu_mul_seq
// Shift-and-add 8x8 multiplier that borrows an external registered ALU for
// its additions. Each multiplier bit costs one SHIFT cycle (bit = 0) or an
// ISSUE + CAPTURE pair (bit = 1), so latency is 9 + popcount(opB) cycles.
//
// Build option: define ALU_MUL_SIGNED_EN to enable two's-complement
// multiplication selected by i_signed. Without it i_signed is ignored and
// every product is unsigned.
//
// Ports
//   i_clk, i_nReset            clock, asynchronous active-low reset
//   i_start, i_signed          start request (sampled in IDLE), signed select
//   i_opA, i_opB               multiplicand, multiplier (captured at start)
//   o_busy, o_done, o_product  status, one-cycle done pulse, 16-bit result
//   o_aluA, o_aluB             ALU A operand (acc high byte), bus operand
//   o_ctrlAluYNWE, o_ctrlAluNOE  ALU result write enable / bus output enable
//                                (both active-low)
//   o_ctrlAluSub, o_ctrlAluOp  ALU subtract and operation select
//   i_aluY, i_aluCarry, i_aluNegative, i_aluOverflow
//                              registered ALU result and flags
// -----------------------------------------------------------------------------
module alu_mul_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_nReset,
    input  logic                 i_start,
    input  logic                 i_signed,
    input  logic [WIDTH-1:0]     i_opA,
    input  logic [WIDTH-1:0]     i_opB,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [2*WIDTH-1:0]   o_product,
    output logic [WIDTH-1:0]     o_aluA,
    output logic [WIDTH-1:0]     o_aluB,
    output logic                 o_ctrlAluYNWE,
    output logic                 o_ctrlAluNOE,
    output logic                 o_ctrlAluSub,
    output logic [1:0]           o_ctrlAluOp,
    input  logic [WIDTH-1:0]     i_aluY,
    input  logic                 i_aluCarry,
    input  logic                 i_aluNegative,
    input  logic                 i_aluOverflow
);

    state_e               state_q, state_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplr_q, mplr_d;
    logic [2:0]           cnt_q, cnt_d;
    logic                 sgn_q, sgn_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;

    logic [2:0]           cnt_nx;
    logic                 cap_top;
    logic                 shf_top;
    logic                 sgn_sel;

`ifdef ALU_MUL_SIGNED_EN
    assign sgn_sel = i_signed;
`else
    logic unused_ok;
    assign sgn_sel   = 1'b0;
    assign unused_ok = i_signed;
`endif

    assign cnt_nx  = cnt_q + 3'd1;
    // N ^ V recovers the true sign of the 9-bit signed sum; carry is the
    // ninth bit of the unsigned sum.
    assign cap_top = sgn_q ? (i_aluNegative ^ i_aluOverflow) : i_aluCarry;
    // Arithmetic shift keeps the partial product's sign when signed.
    assign shf_top = sgn_q & acc_q[2*WIDTH-1];

    always_ff @(posedge i_clk or negedge i_nReset) begin
        if (!i_nReset) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            mcand_q <= '0;
            mplr_q  <= '0;
            cnt_q   <= '0;
            sgn_q   <= 1'b0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            mcand_q <= mcand_d;
            mplr_q  <= mplr_d;
            cnt_q   <= cnt_d;
            sgn_q   <= sgn_d;
            prod_q  <= prod_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        acc_d         = acc_q;
        mcand_d       = mcand_q;
        mplr_d        = mplr_q;
        cnt_d         = cnt_q;
        sgn_d         = sgn_q;
        prod_d        = prod_q;
        o_aluA        = '0;
        o_aluB        = '0;
        o_ctrlAluYNWE = 1'b1;
        o_ctrlAluSub  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_start) begin
                    mcand_d = i_opA;
                    mplr_d  = i_opB;
                    sgn_d   = sgn_sel;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = i_opB[0] ? ST_ISSUE : ST_SHIFT;
                end
            end
            ST_ISSUE: begin
                o_ctrlAluYNWE = 1'b0;
                o_aluA        = acc_q[2*WIDTH-1:WIDTH];
                o_aluB        = mcand_q;
                // The MSB of a two's-complement multiplier has negative weight.
                o_ctrlAluSub  = sgn_q && (cnt_q == LAST_BIT);
                state_d       = ST_CAPTURE;
            end
            ST_CAPTURE, ST_SHIFT: begin
                if (state_q == ST_CAPTURE) begin
                    acc_d = {cap_top, i_aluY, acc_q[WIDTH-1:1]};
                end else begin
                    acc_d = {shf_top, acc_q[2*WIDTH-1:1]};
                end
                if (cnt_q == LAST_BIT) begin
                    // Product is loaded on entry to DONE so it is valid with o_done.
                    prod_d  = acc_d;
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_nx;
                    state_d = mplr_q[cnt_nx] ? ST_ISSUE : ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_busy       = (state_q != ST_IDLE);
    assign o_done       = (state_q == ST_DONE);
    assign o_product    = prod_q;
    assign o_ctrlAluNOE = 1'b1;
    assign o_ctrlAluOp  = ALU_OP_ADD;

endmodule

// File: tb/tb_alu_mul_seq.sv
module tb_alu_mul_seq;

    logic        clk;
    logic        nrst;
    logic        start;
    logic        sgn;
    logic [7:0]  opA, opB;
    logic        busy, done;
    logic [15:0] product;
    logic [7:0]  aluA, aluB;
    logic        ynwe, noe, sub;
    logic [1:0]  aluop;
    logic [7:0]  alu_y;
    logic        alu_c, alu_n, alu_v;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [15:0] prod;
        int          lat;
        longint      t0;
    } exp_t;

    exp_t sb[$];

    alu_mul_seq #(.WIDTH(8)) dut (
        .i_clk         (clk),
        .i_nReset      (nrst),
        .i_start       (start),
        .i_signed      (sgn),
        .i_opA         (opA),
        .i_opB         (opB),
        .o_busy        (busy),
        .o_done        (done),
        .o_product     (product),
        .o_aluA        (aluA),
        .o_aluB        (aluB),
        .o_ctrlAluYNWE (ynwe),
        .o_ctrlAluNOE  (noe),
        .o_ctrlAluSub  (sub),
        .o_ctrlAluOp   (aluop),
        .i_aluY        (alu_y),
        .i_aluCarry    (alu_c),
        .i_aluNegative (alu_n),
        .i_aluOverflow (alu_v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered ALU model: add/subtract with result and flags latched when
    // the write enable (active-low) is asserted.
    logic [7:0] m_bop;
    logic [8:0] m_sum;
    initial begin
        alu_y = 8'h00; alu_c = 1'b0; alu_n = 1'b0; alu_v = 1'b0;
    end
    always @(posedge clk) begin
        if (!ynwe) begin
            m_bop = sub ? ~aluB : aluB;
            m_sum = {1'b0, aluA} + {1'b0, m_bop} + {8'd0, sub};
            alu_y <= m_sum[7:0];
            alu_c <= m_sum[8];
            alu_n <= m_sum[7];
            alu_v <= (aluA[7] == m_bop[7]) && (m_sum[7] != aluA[7]);
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (nrst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                exp_t e;
                int   lat;
                e   = sb.pop_front();
                lat = int'((($time - e.t0) - 5) / 10) + 1;
                chk("product", product, e.prod);
                chk("latency", lat, e.lat);
            end
        end
    end

    task automatic wait_done(output int lows);
        bit found;
        lows  = 0;
        found = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (!ynwe) lows++;
            if (done) found = 1;
        end
        if (!found) chk("done_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (!busy && !done) ok = 1;
        end
        if (!ok) chk("idle_timeout", 0, 1);
    endtask

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic s,
                          input logic [15:0] ep, input int el, output int lows);
        wait_idle();
        opA   = a;
        opB   = b;
        sgn   = s;
        start = 1'b1;
        @(posedge clk);
        sb.push_back('{prod: ep, lat: el, t0: $time});
        #1 start = 1'b0;
        opA = 8'h5A;
        opB = 8'hC3;
        @(negedge clk);
        chk("busy_after_start", busy, 1);
        wait_done(lows);
    endtask

    int lows;

    initial begin
        nrst = 1'b0; start = 1'b0; sgn = 1'b0; opA = 8'h00; opB = 8'h00;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_product", product, 16'h0000);
        chk("rst_ynwe", ynwe, 1);
        chk("rst_noe", noe, 1);
        chk("rst_sub", sub, 0);
        chk("rst_op", aluop, 2'b00);
        chk("rst_aluA", aluA, 8'h00);
        chk("rst_aluB", aluB, 8'h00);
        nrst = 1'b1;

        run_op(8'h0C, 8'h0A, 1'b0, 16'h0078, 11, lows);
        run_op(8'h37, 8'h00, 1'b0, 16'h0000, 9, lows);
        chk("ynwe_low_cycles_zero_mplr", lows, 0);
        run_op(8'h01, 8'hFE, 1'b0, 16'h00FE, 16, lows);
        chk("ynwe_low_cycles_fe", lows, 7);
`ifdef ALU_MUL_SIGNED_EN
        run_op(8'hFF, 8'hFF, 1'b1, 16'h0001, 17, lows);
        run_op(8'h80, 8'h7F, 1'b1, 16'hC080, 16, lows);
        run_op(8'h80, 8'h80, 1'b1, 16'h4000, 10, lows);
`else
        // i_signed has no effect in the unsigned-only build.
        run_op(8'h80, 8'h80, 1'b1, 16'h4000, 10, lows);
`endif
        run_op(8'hFF, 8'hFF, 1'b0, 16'hFE01, 17, lows);
        @(negedge clk);
        chk("idle_aluA", aluA, 8'h00);
        chk("idle_aluB", aluB, 8'h00);
        chk("product_held", product, 16'hFE01);

        // Reset in cycle T+5 of a long multiply: result discarded.
        wait_idle();
        opA = 8'hFF; opB = 8'hFF; sgn = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        nrst = 1'b0;
        #2;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_product", product, 16'h0000);
        chk("midrst_ynwe", ynwe, 1);
        @(negedge clk);
        nrst = 1'b1;
        repeat (20) @(negedge clk);
        chk("post_rst_product", product, 16'h0000);
        run_op(8'h03, 8'h05, 1'b0, 16'h000F, 11, lows);

        // Start held high: each op accepted the cycle after the previous done.
        wait_idle();
        sgn = 1'b0; opA = 8'h12; opB = 8'h34; start = 1'b1;
        @(posedge clk);
        sb.push_back('{prod: 16'h03A8, lat: 12, t0: $time});
        for (int k = 0; k < 3; k++) begin
            #1 opA = 8'hE7; opB = 8'hFF;
            wait_done(lows);
            case (k)
                0: begin opA = 8'h80; opB = 8'h02; end
                1: begin opA = 8'hA5; opB = 8'h81; end
                default: begin opA = 8'h0C; opB = 8'h0A; end
            endcase
            @(posedge clk);
            @(posedge clk);
            case (k)
                0: sb.push_back('{prod: 16'h0100, lat: 10, t0: $time});
                1: sb.push_back('{prod: 16'h5325, lat: 11, t0: $time});
                default: sb.push_back('{prod: 16'h0078, lat: 11, t0: $time});
            endcase
        end
        #1 opA = 8'hE7; opB = 8'hFF;
        wait_done(lows);
        start = 1'b0;
        repeat (25) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/alu_mul_seq.md
ALU_MUL_SEQ -- requirements
Module: alu_mul_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning operand width; only 8 is supported because the ALU datapath is 8 bits.
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port i_nReset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port i_start, input, 1, request to start a multiply; sampled only in IDLE.
REQ-005 SHALL have port i_signed, input, 1, which selects two's-complement operation (see Configuration).
REQ-006 SHALL have port i_opA, input, 8, the multiplicand, captured at start.
REQ-007 SHALL have port i_opB, input, 8, the multiplier, captured at start.
REQ-008 SHALL have port o_busy, output, 1, high from the cycle after start acceptance until o_done.
REQ-009 SHALL have port o_done, output, 1, a one-cycle completion pulse.
REQ-010 SHALL have port o_product, output, 16, the result, held stable from o_done until the next accepted start.
REQ-011 SHALL have port o_aluA, output, 8, driving the ALU A operand (accumulator high byte).
REQ-012 SHALL have port o_aluB, output, 8, driving the ALU bus operand (captured multiplicand).
REQ-013 SHALL have ports o_ctrlAluYNWE, output, 1 and o_ctrlAluNOE, output, 1, both active-low.
REQ-014 SHALL have ports o_ctrlAluSub, output, 1 and o_ctrlAluOp, output, 2.
REQ-015 SHALL have ports i_aluY, input, 8, the registered ALU result, and i_aluCarry, i_aluNegative and i_aluOverflow, input, 1 each, the registered ALU flags.

Function
REQ-016 SHALL implement states IDLE, ISSUE, CAPTURE, SHIFT and DONE.
REQ-017 In IDLE with i_start=1, SHALL latch i_opA, i_opB and i_signed, clear the 16-bit accumulator and the bit counter, and go to ISSUE if opB[0]=1, else to SHIFT.
REQ-018 In ISSUE, SHALL drive o_ctrlAluOp=00 (ADD), o_ctrlAluYNWE=0, o_aluA=acc[15:8] and o_aluB=multiplicand.
REQ-019 In ISSUE, SHALL drive o_ctrlAluSub=1 only on the bit-7 iteration of a signed multiply, and 0 otherwise.
REQ-020 In CAPTURE, SHALL set acc = {top, i_aluY, acc[7:1]}, where top = i_aluCarry when unsigned and top = i_aluNegative XOR i_aluOverflow when signed.
REQ-021 In SHIFT, SHALL set acc = {top, acc[15:1]}, where top = 0 when unsigned and top = acc[15] when signed.
REQ-022 After CAPTURE or SHIFT, SHALL increment the bit counter, then go to ISSUE or SHIFT according to the next multiplier bit, or go to DONE after bit 7.
REQ-023 In DONE, SHALL pulse o_done, load o_product=acc, and return to IDLE.
REQ-024 Latency SHALL be exact: for start sampled at edge T, o_done SHALL be high in cycle T+9+popcount(opB), giving a range of 9 to 17 cycles.
REQ-025 Outside ISSUE, SHALL hold o_ctrlAluYNWE=1.
REQ-026 SHALL hold o_ctrlAluNOE=1 always, so the ALU never drives the shared bus while sequenced.
REQ-027 SHALL ignore i_start while busy or in DONE; no queuing.
REQ-028 Back-to-back operation: a start in the cycle immediately after o_done SHALL be accepted.
REQ-029 o_aluA and o_aluB SHALL be 0 in IDLE.

Reset
REQ-030 Asserting i_nReset low at any time, including mid-operation, SHALL force IDLE.
REQ-031 On reset, o_busy=0, o_done=0, o_product=0, o_ctrlAluYNWE=1, o_ctrlAluNOE=1, o_ctrlAluSub=0 and o_ctrlAluOp=00.
REQ-032 An operation interrupted by reset SHALL be discarded; no o_done is produced for it.

Configuration
REQ-033 Macro ALU_MUL_SIGNED_EN SHALL control signed support.
REQ-034 With ALU_MUL_SIGNED_EN defined, i_signed=1 SHALL select signed operation per REQ-019 to REQ-021.
REQ-035 Without ALU_MUL_SIGNED_EN, i_signed SHALL be ignored, o_ctrlAluSub SHALL be constant 0, and all products SHALL be unsigned.

Structure
REQ-036 Package alu_seq_pkg SHALL hold the state enum and the ALU op constants ALU_OP_ADD=00, ALU_OP_AND=01, ALU_OP_XOR=10 and ALU_OP_SHIFT=11.
REQ-037 SHALL contain no sub-module; the bench SHALL instantiate the existing ALU alongside alu_mul_seq, wiring ALU o_bus to i_aluY and the ALU flags to the flag inputs.

Verification
REQ-038 Unsigned 0x0C x 0x0A -> o_product=0x0078, with o_done at T+11.
REQ-039 Unsigned 0xFF x 0xFF -> o_product=0xFE01, with o_done at T+17.
REQ-040 Unsigned 0x37 x 0x00 -> o_product=0x0000, with o_done at T+9 and o_ctrlAluYNWE never low.
REQ-041 With ALU_MUL_SIGNED_EN, signed 0xFF x 0xFF -> 0x0001, signed 0x80 x 0x7F -> 0xC080, and signed 0x80 x 0x80 -> 0x4000.
REQ-042 i_nReset pulsed low in cycle T+5 of 0xFF x 0xFF -> state IDLE, no o_done, o_product=0; a following 0x03 x 0x05 -> 0x000F.
REQ-043 i_start held high continuously with new operands -> each operation completes and the next is accepted in the cycle after o_done; starts seen while busy are ignored.
